// File: rtl/matrix_mul_seq.sv
// ---------------------------------------------------------------------------
// matrix_mul_seq
//   Sequential NxN unsigned matrix multiplier, C = A x B, one multiply-
//   accumulate per clock. Operands are captured when a start request is
//   accepted. Each result element is narrowed to DW bits and written to the
//   registered output as soon as its dot product completes.
//
// Parameters
//   N    matrix dimension (2..8)
//   DW   element width in bits (unsigned)
//   SAT  narrowing mode: 0 = keep low DW bits, 1 = saturate to 2^DW-1
//
// Ports
//   clk     clock, all state updates on the rising edge
//   rst     synchronous active-high reset
//   start   request to begin a multiplication (honoured only when idle)
//   a_flat  matrix A, row-major, element (i,k) at [(i*N+k)*DW +: DW]
//   b_flat  matrix B, same layout
//   busy    high while the multiply-accumulate sequence runs (N^3 cycles)
//   done    one-cycle completion pulse
//   c_flat  result matrix C, same layout, registered
// ---------------------------------------------------------------------------
module matrix_mul_seq #(
  parameter int N   = 4,
  parameter int DW  = 16,
  parameter int SAT = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [N*N*DW-1:0] a_flat,
  input  logic [N*N*DW-1:0] b_flat,
  output logic              busy,
  output logic              done,
  output logic [N*N*DW-1:0] c_flat
);

  localparam int IW   = $clog2(N);
  localparam int PW   = 2 * DW;
  // Worst case sum is N*(2^DW-1)^2, which fits in 2*DW + clog2(N) bits.
  localparam int ACCW = 2 * DW + $clog2(N);
  localparam logic [IW-1:0] IDX_MAX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [N*N*DW-1:0]   a_q, a_d;
  logic [N*N*DW-1:0]   b_q, b_d;
  logic [IW-1:0]       i_q, i_d;
  logic [IW-1:0]       j_q, j_d;
  logic [IW-1:0]       k_q, k_d;
  logic [ACCW-1:0]     acc_q, acc_d;
  logic [DW-1:0]       c_q [N][N];
  logic [DW-1:0]       c_d [N][N];

  // Operand / result views as 2-D arrays
  logic [DW-1:0]       a_m [N][N];
  logic [DW-1:0]       b_m [N][N];

  logic [PW-1:0]       prod;
  logic [ACCW-1:0]     sum;
  logic [DW-1:0]       c_new;

  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gk = 0; gk < N; gk++) begin : g_col
      assign a_m[gi][gk] = a_q[(gi*N+gk)*DW +: DW];
      assign b_m[gi][gk] = b_q[(gi*N+gk)*DW +: DW];
      assign c_flat[(gi*N+gk)*DW +: DW] = c_q[gi][gk];
    end
  end

  // Datapath: current product, running sum including it, narrowed result.
  always_comb begin
    prod = PW'(a_m[i_q][k_q]) * PW'(b_m[k_q][j_q]);
    sum  = acc_q + ACCW'(prod);
    if ((SAT != 0) && (|sum[ACCW-1:DW])) begin
      c_new = '1;
    end else begin
      c_new = sum[DW-1:0];
    end
  end

  // Next-state and control
  always_comb begin
    // NOTE: every signal gets its hold value first so no path leaves one unassigned (no latch).
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    i_d     = i_q;
    j_d     = j_q;
    k_d     = k_q;
    acc_d   = acc_q;
    c_d     = c_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = a_flat;
          b_d     = b_flat;
          i_d     = '0;
          j_d     = '0;
          k_d     = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end

      RUN: begin
        if (k_q == IDX_MAX) begin
          // Last term of this dot product: publish and restart the sum.
          c_d[i_q][j_q] = c_new;
          acc_d         = '0;
          k_d           = '0;
          if (j_q == IDX_MAX) begin
            j_d = '0;
            if (i_q == IDX_MAX) begin
              i_d     = '0;
              state_d = DONE;
            end else begin
              i_d = i_q + IW'(1);
            end
          end else begin
            j_d = j_q + IW'(1);
          end
        end else begin
          acc_d = sum;
          k_d   = k_q + IW'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: operand and result storage is cleared too, so an aborted run leaves no stale data visible.
      a_q     <= '0;
      b_q     <= '0;
      i_q     <= '0;
      j_q     <= '0;
      k_q     <= '0;
      acc_q   <= '0;
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N; c++) begin
          c_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      i_q     <= i_d;
      j_q     <= j_d;
      k_q     <= k_d;
      acc_q   <= acc_d;
      c_q     <= c_d;
    end
  end

endmodule

// File: tb/tb_matrix_mul_seq.sv
// ---------------------------------------------------------------------------
// tb_matrix_mul_seq
//   Two N=4/DW=16 instances (truncating and saturating) share stimulus and
//   are checked every cycle against a matrix-level model; an N=2/DW=8
//   instance gets a directed check. Directed tests also compare against
//   hand-computed literals.
// ---------------------------------------------------------------------------
module tb_matrix_mul_seq;

  localparam int NM    = 4;
  localparam int NCUBE = NM * NM * NM;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [255:0] a_in, b_in;
  logic         busy, done, busy_s, done_s;
  logic [255:0] c_flat, c_s;

  logic         start2;
  logic [31:0]  a2, b2, c2;
  logic         busy2, done2;

  int n_vec  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  matrix_mul_seq #(.N(4), .DW(16), .SAT(0)) u_trunc (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_in), .b_flat(b_in),
    .busy(busy), .done(done), .c_flat(c_flat)
  );

  matrix_mul_seq #(.N(4), .DW(16), .SAT(1)) u_sat (
    .clk(clk), .rst(rst), .start(start), .a_flat(a_in), .b_flat(b_in),
    .busy(busy_s), .done(done_s), .c_flat(c_s)
  );

  matrix_mul_seq #(.N(2), .DW(8), .SAT(0)) u_n2 (
    .clk(clk), .rst(rst), .start(start2), .a_flat(a2), .b_flat(b2),
    .busy(busy2), .done(done2), .c_flat(c2)
  );

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // ---------------- matrix-level model ----------------
  // Full product computed at acceptance; element e becomes visible after the
  // (e+1)*N-th edge of the run; busy for N^3 cycles, then one done cycle.
  bit           m_active = 1'b0;
  int           m_cnt    = 0;
  logic [255:0] m_full0, m_full1;
  logic [255:0] m_c0 = '0, m_c1 = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_active = 1'b0;
      m_cnt    = 0;
      m_c0     = '0;
      m_c1     = '0;
    end else if (!m_active) begin
      if (start) begin
        for (int i = 0; i < NM; i++) begin
          for (int j = 0; j < NM; j++) begin
            logic [63:0] s;
            s = 0;
            for (int k = 0; k < NM; k++) begin
              s += 64'(a_in[(i*NM+k)*16 +: 16]) * 64'(b_in[(k*NM+j)*16 +: 16]);
            end
            m_full0[(i*NM+j)*16 +: 16] = s[15:0];
            m_full1[(i*NM+j)*16 +: 16] = (s > 64'hFFFF) ? 16'hFFFF : s[15:0];
          end
        end
        m_active = 1'b1;
        m_cnt    = 0;
      end
    end else begin
      m_cnt++;
      if (m_cnt <= NCUBE && (m_cnt % NM) == 0) begin
        int e;
        e = m_cnt / NM - 1;
        m_c0[e*16 +: 16] = m_full0[e*16 +: 16];
        m_c1[e*16 +: 16] = m_full1[e*16 +: 16];
      end
      if (m_cnt == NCUBE + 1) m_active = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy",   256'(busy),   256'(m_active && m_cnt < NCUBE));
      check("done",   256'(done),   256'(m_active && m_cnt == NCUBE));
      check("busy_s", 256'(busy_s), 256'(m_active && m_cnt < NCUBE));
      check("done_s", 256'(done_s), 256'(m_active && m_cnt == NCUBE));
      check("c_trunc", c_flat, m_c0);
      check("c_sat",   c_s,    m_c1);
    end
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [255:0] ident(input int s);
    logic [255:0] r;
    r = '0;
    for (int i = 0; i < NM; i++) r[(i*NM+i)*16 +: 16] = 16'(s);
    return r;
  endfunction

  function automatic logic [255:0] pat(input int mi, input int mj, input int c0);
    logic [255:0] r;
    for (int i = 0; i < NM; i++)
      for (int j = 0; j < NM; j++)
        r[(i*NM+j)*16 +: 16] = 16'(mi*i + mj*j + c0);
    return r;
  endfunction

  // Leaves the caller at the negedge of cycle 1 after the accepting edge.
  task automatic pulse_start(input logic [255:0] a, input logic [255:0] b);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 1;
    bcnt = 0;
    while (!done && cyc < 200) begin
      if (busy) bcnt++;
      @(negedge clk);
      cyc++;
    end
  endtask

  int           cyc, bcnt, dcnt, done_at, gap;
  logic [255:0] exp_v, c_snap;

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    start2 = 1'b0;
    a_in   = '0;
    b_in   = '0;
    a2     = '0;
    b2     = '0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Reset state
    check("rst_busy", 256'(busy), 256'(0));
    check("rst_done", 256'(done), 256'(0));
    check("rst_c",    c_flat,     256'(0));

    // Identity: C must equal B, done on cycle 65, busy for 64 cycles
    pulse_start(ident(1), pat(16, 1, 0));
    wait_done(cyc, bcnt);
    check("id_done_cycle", 256'(cyc),  256'(65));
    check("id_busy_cnt",   256'(bcnt), 256'(64));
    check("id_c",          c_flat,     pat(16, 1, 0));
    repeat (3) @(negedge clk);

    // Overflow: raw sum 0x3_FFF8_0004 per element
    pulse_start('1, '1);
    wait_done(cyc, bcnt);
    for (int e = 0; e < NM*NM; e++) exp_v[e*16 +: 16] = 16'h0004;
    check("ovf_trunc", c_flat, exp_v);
    check("ovf_sat",   c_s,    '1);
    repeat (3) @(negedge clk);

    // Start re-pulsed with new operands at cycles 10 and 40 is ignored
    pulse_start(ident(1), pat(3, 7, 1));
    cyc = 1; dcnt = 0; done_at = 0; c_snap = '0;
    while (cyc < 80) begin
      if (cyc == 10 || cyc == 40) begin
        a_in  = pat(5, 1, 2);
        b_in  = pat(1, 9, 4);
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        dcnt++;
        done_at = cyc;
        c_snap  = c_flat;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("bs_done_cnt", 256'(dcnt),    256'(1));
    check("bs_done_at",  256'(done_at), 256'(65));
    check("bs_c_done",   c_snap,        pat(3, 7, 1));
    check("bs_c_hold",   c_flat,        pat(3, 7, 1));

    // Mid-run reset at cycle 30, with start asserted on the reset edge
    pulse_start(pat(1, 2, 3), pat(2, 1, 1));
    repeat (29) @(negedge clk);
    rst   = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;
    check("mr_busy", 256'(busy), 256'(0));
    check("mr_done", 256'(done), 256'(0));
    check("mr_c",    c_flat,     256'(0));
    @(negedge clk);
    check("mr_no_accept", 256'(busy), 256'(0));
    pulse_start(ident(1), pat(16, 1, 0));
    wait_done(cyc, bcnt);
    check("mr_done_cycle", 256'(cyc), 256'(65));
    check("mr_c_after",    c_flat,    pat(16, 1, 0));
    repeat (3) @(negedge clk);

    // Back-to-back: start held high, second operands presented after accept
    a_in  = ident(1);
    b_in  = pat(16, 1, 0);
    start = 1'b1;
    @(negedge clk);
    a_in  = ident(2);
    wait_done(cyc, bcnt);
    check("b2b_done1", 256'(cyc), 256'(65));
    check("b2b_c1",    c_flat,    pat(16, 1, 0));
    gap = 0;
    @(negedge clk); gap++;
    @(negedge clk); gap++;
    start = 1'b0;
    while (!done && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    check("b2b_gap", 256'(gap), 256'(66));
    check("b2b_c2",  c_flat,    pat(32, 2, 0));
    repeat (3) @(negedge clk);

    // N=2, DW=8: [[1,2],[3,4]] x [[5,6],[7,8]] = [[19,22],[43,50]]
    a2     = 32'h04030201;
    b2     = 32'h08070605;
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    cyc = 1; bcnt = 0;
    while (!done2 && cyc < 50) begin
      if (busy2) bcnt++;
      @(negedge clk);
      cyc++;
    end
    check("n2_done_cycle", 256'(cyc),  256'(9));
    check("n2_busy_cnt",   256'(bcnt), 256'(8));
    check("n2_c",          256'(c2),   256'(32'h322B1613));
    @(negedge clk);
    check("n2_done_pulse", 256'(done2), 256'(0));

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
